fb_port_arbiter: RTL

Shares one single-port frame-buffer BRAM (80x60 pixels, 12-bit RGB444 words) between two requesters: the camera capture writer and the VGA display reader. Display reads have strict priority and a fixed latency, because the display path cannot stall. Camera writes are absorbed in a small write FIFO and drained in cycles the display does not use. The block sits between the capture block, the frame-buffer BRAM and the VGA display block.

---
 rtl/fb_port_arbiter_if.sv | 31 +++
 rtl/fb_port_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter_if.sv
// Bundle of display, camera and frame-buffer BRAM signals around the frame-buffer port arbiter.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface fb_port_arbiter_if #(
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12
);
    logic                     disp_req;
    logic [c_nb_img_pxls-1:0] disp_addr;
    logic [c_nb_buf-1:0]      disp_data;
    logic                     disp_valid;
    logic                     cam_we;
    logic [c_nb_img_pxls-1:0] cam_addr;
    logic [c_nb_buf-1:0]      cam_data;
    logic                     cam_full;
    logic                     ovf;
    logic                     ovf_clr;
    logic [c_nb_img_pxls-1:0] mem_addr;
    logic                     mem_we;
    logic [c_nb_buf-1:0]      mem_din;
    logic [c_nb_buf-1:0]      mem_dout;

    modport slave (
        input  disp_req, disp_addr, cam_we, cam_addr, cam_data, ovf_clr, mem_dout,
        output disp_data, disp_valid, cam_full, ovf, mem_addr, mem_we, mem_din
    );

    modport master (
        output disp_req, disp_addr, cam_we, cam_addr, cam_data, ovf_clr, mem_dout,
        input  disp_data, disp_valid, cam_full, ovf, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win every cycle, camera writes queue in a FIFO.
// Optional FB_ARB_STATS_EN adds saturating stall_cnt/drop_cnt outputs.
module fb_port_arbiter #(
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12,
    parameter int unsigned c_nb_fifo     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_port_arbiter_if.slave     bus
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          drop_cnt
`endif
);

    localparam int unsigned Depth = 1 << c_nb_fifo;
    localparam logic [c_nb_fifo:0] DepthCnt = (c_nb_fifo + 1)'(Depth);

    logic [c_nb_img_pxls-1:0] fifo_addr_q [Depth];
    logic [c_nb_buf-1:0]      fifo_data_q [Depth];

    logic [c_nb_fifo-1:0]     wr_ptr_q, rd_ptr_q;
    logic [c_nb_fifo:0]       count_q, count_d;
    logic                     cam_full_q;
    logic                     ovf_q;
    logic [c_nb_img_pxls-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_we_d;
    logic                     rd_pend_q;
    logic                     disp_valid_q;
    logic [c_nb_buf-1:0]      disp_data_q;

    logic full, push, pop, drop;

    // Full comes from the registered count, so a same-cycle pop never frees a slot for a push.
    assign full = (count_q == DepthCnt);
    assign push = bus.cam_we && !full;
    assign drop = bus.cam_we && full;
    assign pop  = !bus.disp_req && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        if (bus.disp_req) begin
            mem_addr_d = bus.disp_addr;
        end else if (pop) begin
            mem_addr_d = fifo_addr_q[rd_ptr_q];
            mem_we_d   = 1'b1;
        end
    end

    assign bus.mem_addr   = mem_addr_d;
    assign bus.mem_we     = mem_we_d;
    assign bus.mem_din    = fifo_data_q[rd_ptr_q];
    assign bus.cam_full   = cam_full_q;
    assign bus.ovf        = ovf_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_data  = disp_data_q;

    // FIFO storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.cam_addr;
            fifo_data_q[wr_ptr_q] <= bus.cam_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cam_full_q   <= 1'b0;
            ovf_q        <= 1'b0;
            mem_addr_q   <= '0;
            rd_pend_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            cam_full_q <= (count_d == DepthCnt);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
            mem_addr_q   <= mem_addr_d;
            // BRAM data appears the cycle after the request; capture it one cycle later.
            rd_pend_q    <= bus.disp_req;
            disp_valid_q <= rd_pend_q;
            if (rd_pend_q) disp_data_q <= bus.mem_dout;
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, drop_cnt_q;
    logic        stall;

    assign stall = bus.disp_req && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (bus.ovf_clr) begin
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (drop && (drop_cnt_q != 16'hFFFF))   drop_cnt_q  <= drop_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule
